// File: rtl/salu_wave_arbiter_if.sv
// Wave-side request, SALU issue and result-return signals of salu_wave_arbiter.
// prio_i exists only when SALU_ARB_PRIO_EN is defined.
interface salu_wave_arbiter_if #(
    parameter int NUM_WAVES = 4,
    parameter int INSTR_W   = 32
);
    localparam int WID_W = $clog2(NUM_WAVES);

    logic [NUM_WAVES-1:0]         wave_valid_i;
    logic [NUM_WAVES*INSTR_W-1:0] wave_instr_i;
    logic [NUM_WAVES-1:0]         wave_ready_o;
    logic                         issue_valid_o;
    logic                         issue_ready_i;
    logic [INSTR_W-1:0]           issue_instr_o;
    logic [WID_W-1:0]             issue_wave_o;
    logic                         result_valid_i;
    logic [WID_W-1:0]             result_wave_i;
    logic [NUM_WAVES-1:0]         busy_o;
    logic                         err_o;
`ifdef SALU_ARB_PRIO_EN
    logic [NUM_WAVES-1:0]         prio_i;
`endif

    modport slave (
        input  wave_valid_i, wave_instr_i, issue_ready_i, result_valid_i, result_wave_i,
`ifdef SALU_ARB_PRIO_EN
        input  prio_i,
`endif
        output wave_ready_o, issue_valid_o, issue_instr_o, issue_wave_o, busy_o, err_o
    );

    modport master (
        output wave_valid_i, wave_instr_i, issue_ready_i, result_valid_i, result_wave_i,
`ifdef SALU_ARB_PRIO_EN
        output prio_i,
`endif
        input  wave_ready_o, issue_valid_o, issue_instr_o, issue_wave_o, busy_o, err_o
    );
endinterface

// File: rtl/salu_wave_arbiter.sv
// Round-robin arbiter sharing one SALU among NUM_WAVES wavefronts, one op in flight per wave.
// Optional macro SALU_ARB_PRIO_EN: restricts the round-robin search to prio_i waves when any is eligible.
module salu_wave_arbiter #(
    parameter int NUM_WAVES = 4,
    parameter int INSTR_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    salu_wave_arbiter_if.slave bus
);
    localparam int WID_W = $clog2(NUM_WAVES);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t               r_state;
    logic [NUM_WAVES-1:0] r_busy;
    logic                 r_err;
    logic [WID_W-1:0]     r_rr_ptr;
    logic [WID_W-1:0]     r_issue_wave;
    logic [INSTR_W-1:0]   r_issue_instr;

    logic [NUM_WAVES-1:0] w_elig, w_cand, w_grant_oh, w_busy_clr;
    logic [WID_W-1:0]     w_winner;
    logic                 w_found, w_load, w_grant, w_res_ok, w_res_bad;

    // Walk offsets high to low so the lowest offset from ptr wins.
    function automatic logic [WID_W:0] f_pick(input logic [NUM_WAVES-1:0] cand,
                                              input logic [WID_W-1:0]     ptr);
        logic [WID_W:0] res;
        int             idx;
        res = '0;
        for (int i = NUM_WAVES - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_WAVES;
            if (cand[idx]) res = {1'b1, WID_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        w_elig = bus.wave_valid_i & ~r_busy;
`ifdef SALU_ARB_PRIO_EN
        w_cand = (|(w_elig & bus.prio_i)) ? (w_elig & bus.prio_i) : w_elig;
`else
        w_cand = w_elig;
`endif
        {w_found, w_winner} = f_pick(w_cand, r_rr_ptr);
        w_load     = (r_state == S_EMPTY) | bus.issue_ready_i;
        w_grant    = rst_n & w_load & w_found;
        w_grant_oh = w_grant ? (NUM_WAVES'(1) << w_winner) : '0;

        // A result only counts when it targets a wave that really has an op in flight.
        w_res_ok   = bus.result_valid_i && (int'(bus.result_wave_i) < NUM_WAVES) &&
                     r_busy[bus.result_wave_i];
        w_res_bad  = bus.result_valid_i & ~w_res_ok;
        w_busy_clr = w_res_ok ? (NUM_WAVES'(1) << bus.result_wave_i) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_EMPTY;
            r_busy        <= '0;
            r_err         <= 1'b0;
            r_rr_ptr      <= '0;
            r_issue_wave  <= '0;
            r_issue_instr <= '0;
        end else begin
            // Grant and clear never hit the same wave: grant needs busy=0, clear needs busy=1.
            r_busy <= (r_busy & ~w_busy_clr) | w_grant_oh;
            if (w_res_bad) r_err <= 1'b1;
            if (w_grant) begin
                r_state       <= S_FULL;
                r_issue_instr <= bus.wave_instr_i[int'(w_winner)*INSTR_W +: INSTR_W];
                r_issue_wave  <= w_winner;
                r_rr_ptr      <= (w_winner == WID_W'(NUM_WAVES - 1)) ? '0 : w_winner + 1'b1;
            end else if (w_load) begin
                r_state <= S_EMPTY;
            end
        end
    end

    assign bus.wave_ready_o  = w_grant_oh;
    assign bus.issue_valid_o = (r_state == S_FULL);
    assign bus.issue_instr_o = r_issue_instr;
    assign bus.issue_wave_o  = r_issue_wave;
    assign bus.busy_o        = r_busy;
    assign bus.err_o         = r_err;
endmodule
